pipe_stage_buf: RTL and testbench

- Parametrised pipeline-stage register; generic successor to the fixed decode/ALU stage buffer.
- Carries a control bundle (WB/Mem/Ex) plus a data payload between any two pipeline stages.
- Adds valid/ready handshaking, an optional 2-entry skid slot, flush-to-bubble and a saturating stall counter.
- Instantiated between every stage pair: fetch/decode, decode/ALU, ALU/mem, mem/WB.

---
 rtl/pipe_stage_buf_pkg.sv | 30 +++
 rtl/pipe_stage_buf_if.sv | 31 +++
 rtl/pipe_stage_buf_slot.sv | 38 +++
 rtl/pipe_stage_buf.sv | 102 ++++++++++
 tb/tb_pipe_stage_buf.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared types and constants for the pipeline stage buffer.
package pipe_buf_pkg;

  localparam int WB_W   = 2;
  localparam int MEM_W  = 9;
  localparam int EX_W   = 14;
  localparam int CTRL_W = WB_W + MEM_W + EX_W;

  // Field offsets into the control bundle, Ex in the low bits.
  localparam int EX_LSB  = 0;
  localparam int MEM_LSB = EX_W;
  localparam int WB_LSB  = EX_W + MEM_W;

  // Encoding matches {s_valid, m_valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FULL  = 2'b11
  } buf_state_t;

  // The skid slot is never valid while the main slot is empty.
  function automatic buf_state_t state_of(input logic s_valid, input logic m_valid);
    case ({s_valid, m_valid})
      2'b00:   return EMPTY;
      2'b01:   return HALF;
      default: return FULL;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Handshake and bus signals of one pipeline stage buffer.
interface pipe_stage_buf_if #(
  parameter int CTRL_W = 25,
  parameter int DATA_W = 90,
  parameter int CNT_W  = 16
) ();

  logic              i_valid;
  logic              o_ready;
  logic [CTRL_W-1:0] i_ctrl;
  logic [DATA_W-1:0] i_data;
  logic              i_flush;
  logic              o_valid;
  logic              i_ready;
  logic [CTRL_W-1:0] o_ctrl;
  logic [DATA_W-1:0] o_data;
  logic [CNT_W-1:0]  o_stall_cnt;

  // The buffer itself.
  modport slave (
    input  i_valid, i_ctrl, i_data, i_flush, i_ready,
    output o_ready, o_valid, o_ctrl, o_data, o_stall_cnt
  );

  // The surrounding pipeline (upstream producer plus downstream consumer).
  modport master (
    output i_valid, i_ctrl, i_data, i_flush, i_ready,
    input  o_ready, o_valid, o_ctrl, o_data, o_stall_cnt
  );

endinterface

// File: rtl/pipe_stage_buf_slot.sv
// One valid+ctrl+data holding register of the stage buffer.
module pipe_buf_slot #(
  parameter int CTRL_W = 25,
  parameter int DATA_W = 90
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drop,
  input  logic              clear,
  input  logic              clear_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Priority: reset, flush clear, load, drop; contents move only on load.
  always_ff @(negedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (clear_data) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      data  <= d_data;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready, optional skid slot, flush and
// a saturating stall counter. All state moves on the falling clock edge.
module pipe_stage_buf #(
  parameter int CTRL_W            = pipe_buf_pkg::CTRL_W,
  parameter int DATA_W            = 90,
  parameter int SKID              = 1,
  parameter int CLR_DATA_ON_FLUSH = 0,
  parameter int CNT_W             = 16
) (
  input logic            clk,
  input logic            rst,
  pipe_stage_buf_if.slave bus
);
  import pipe_buf_pkg::*;

  logic              accept, emit, ready;
  logic              m_valid, m_load, m_drop;
  logic [CTRL_W-1:0] m_ctrl, m_ctrl_d;
  logic [DATA_W-1:0] m_data, m_data_d;
  logic [CNT_W-1:0]  stall_cnt;
  logic              clr_data;

  assign accept   = bus.i_valid & ready;
  assign emit     = m_valid & bus.i_ready;
  assign clr_data = (CLR_DATA_ON_FLUSH != 0);

  assign bus.o_ready     = ready;
  assign bus.o_valid     = m_valid;
  assign bus.o_ctrl      = m_valid ? m_ctrl : '0;
  assign bus.o_data      = m_data;
  assign bus.o_stall_cnt = stall_cnt;

  pipe_buf_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk        (clk),
    .rst        (rst),
    .load       (m_load),
    .drop       (m_drop),
    .clear      (bus.i_flush),
    .clear_data (clr_data),
    .d_ctrl     (m_ctrl_d),
    .d_data     (m_data_d),
    .valid      (m_valid),
    .ctrl       (m_ctrl),
    .data       (m_data)
  );

  if (SKID != 0) begin : g_skid
    logic              s_valid, s_load, s_drop, ready_q;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;
    buf_state_t        state;

    assign state = state_of(s_valid, m_valid);

    // FULL refills main from skid; otherwise main takes the incoming beat.
    assign m_load   = (state == FULL) ? emit : (accept & ((state == EMPTY) | emit));
    assign m_drop   = (state == HALF) & !accept & emit;
    assign s_load   = (state == HALF) & accept & !emit;
    assign s_drop   = (state == FULL) & emit;
    assign m_ctrl_d = (state == FULL) ? s_ctrl : bus.i_ctrl;
    assign m_data_d = (state == FULL) ? s_data : bus.i_data;

    pipe_buf_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk        (clk),
      .rst        (rst),
      .load       (s_load),
      .drop       (s_drop),
      .clear      (bus.i_flush),
      .clear_data (clr_data),
      .d_ctrl     (bus.i_ctrl),
      .d_data     (bus.i_data),
      .valid      (s_valid),
      .ctrl       (s_ctrl),
      .data       (s_data)
    );

    // Registered ready tracks the next value of !s_valid.
    always_ff @(negedge clk) begin
      if (!rst)             ready_q <= 1'b1;
      else if (bus.i_flush) ready_q <= 1'b1;
      else if (s_load)      ready_q <= 1'b0;
      else if (s_drop)      ready_q <= 1'b1;
    end

    assign ready = ready_q;
  end else begin : g_single
    assign ready    = !m_valid | bus.i_ready;
    assign m_load   = accept;
    assign m_drop   = emit & !accept;
    assign m_ctrl_d = bus.i_ctrl;
    assign m_data_d = bus.i_data;
  end

  // Count edges where a held beat is refused downstream; saturate, keep through flush.
  always_ff @(negedge clk) begin
    if (!rst)
      stall_cnt <= '0;
    else if (m_valid && !bus.i_ready && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: skid, single-slot and narrow-counter builds.
module tb_pipe_stage_buf;

  logic clk = 1'b1;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  pipe_stage_buf_if ia ();
  pipe_stage_buf_if ib ();
  pipe_stage_buf_if #(.CNT_W(4)) ic ();

  pipe_stage_buf dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  pipe_stage_buf #(.SKID(0)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  pipe_stage_buf #(.CNT_W(4), .CLR_DATA_ON_FLUSH(1)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance through one falling (update) edge, then settle.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    ia.i_valid = 1'b1; ia.i_ctrl = 25'h1F; ia.i_data = 90'h5A; ia.i_flush = 1'b0; ia.i_ready = 1'b0;
    ib.i_valid = 1'b0; ib.i_ctrl = '0;     ib.i_data = '0;     ib.i_flush = 1'b0; ib.i_ready = 1'b1;
    ic.i_valid = 1'b0; ic.i_ctrl = '0;     ic.i_data = '0;     ic.i_flush = 1'b0; ic.i_ready = 1'b1;

    // Reset held for two edges with a valid beat offered.
    step(); step();
    check("rst_valid", ia.o_valid, 0);
    check("rst_ctrl",  ia.o_ctrl, 0);
    check("rst_data",  ia.o_data, 0);
    check("rst_ready", ia.o_ready, 1);
    check("rst_cnt",   ia.o_stall_cnt, 0);

    // Streaming with downstream always ready.
    rst = 1'b1;
    ia.i_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      ia.i_valid = 1'b1; ia.i_ctrl = 25'(k); ia.i_data = 90'(16 * k + k);
      step();
      check("stream_valid", ia.o_valid, 1);
      check("stream_ctrl",  ia.o_ctrl, k);
      check("stream_data",  ia.o_data, 16 * k + k);
      check("stream_ready", ia.o_ready, 1);
    end
    ia.i_valid = 1'b0;
    step();
    check("stream_drain_valid", ia.o_valid, 0);
    check("stream_drain_ctrl",  ia.o_ctrl, 0);
    check("stream_cnt",         ia.o_stall_cnt, 0);

    // Skid fill: A then B while downstream stalls, C refused.
    ia.i_ready = 1'b0;
    ia.i_valid = 1'b1; ia.i_ctrl = 25'hA; ia.i_data = 90'hAAA;
    step();
    check("fill_a_ctrl",  ia.o_ctrl, 25'hA);
    check("fill_a_ready", ia.o_ready, 1);
    ia.i_ctrl = 25'hB; ia.i_data = 90'hBBB;
    step();
    check("fill_b_ctrl",  ia.o_ctrl, 25'hA);
    check("fill_b_ready", ia.o_ready, 0);
    check("fill_b_cnt",   ia.o_stall_cnt, 1);
    ia.i_ctrl = 25'hC; ia.i_data = 90'hCCC;
    step();
    check("fill_c_ctrl", ia.o_ctrl, 25'hA);
    check("fill_c_data", ia.o_data, 90'hAAA);
    check("fill_c_cnt",  ia.o_stall_cnt, 2);
    ia.i_valid = 1'b0;
    ia.i_ready = 1'b1;
    step();
    check("drain_b_ctrl",  ia.o_ctrl, 25'hB);
    check("drain_b_data",  ia.o_data, 90'hBBB);
    check("drain_b_ready", ia.o_ready, 1);
    check("drain_b_cnt",   ia.o_stall_cnt, 2);
    step();
    check("drain_empty_valid", ia.o_valid, 0);
    check("drain_empty_cnt",   ia.o_stall_cnt, 2);

    // Flush while FULL with beat D offered; payload retained in this build.
    ia.i_ready = 1'b0;
    ia.i_valid = 1'b1; ia.i_ctrl = 25'h15; ia.i_data = 90'hA5A5;
    step();
    ia.i_ctrl = 25'h16; ia.i_data = 90'hB6B6;
    step();
    check("pre_flush_ready", ia.o_ready, 0);
    ia.i_flush = 1'b1; ia.i_ctrl = 25'hD; ia.i_data = 90'hDDD;
    step();
    check("flush_valid", ia.o_valid, 0);
    check("flush_ctrl",  ia.o_ctrl, 0);
    check("flush_data",  ia.o_data, 90'hA5A5);
    check("flush_ready", ia.o_ready, 1);
    check("flush_cnt",   ia.o_stall_cnt, 4);
    ia.i_flush = 1'b0; ia.i_valid = 1'b0; ia.i_ready = 1'b1;
    step();
    check("post_flush_valid", ia.o_valid, 0);
    check("post_flush_data",  ia.o_data, 90'hA5A5);

    // Single-slot back-pressure and same-edge replace.
    ib.i_ready = 1'b0;
    ib.i_valid = 1'b1; ib.i_ctrl = 25'h7; ib.i_data = 90'h77;
    step();
    ib.i_valid = 1'b0;
    #1;
    check("s0_full_ready", ib.o_ready, 0);
    check("s0_full_ctrl",  ib.o_ctrl, 25'h7);
    ib.i_ready = 1'b1;
    #1;
    check("s0_comb_ready", ib.o_ready, 1);
    ib.i_valid = 1'b1; ib.i_ctrl = 25'h8; ib.i_data = 90'h88;
    step();
    check("s0_replace_valid", ib.o_valid, 1);
    check("s0_replace_ctrl",  ib.o_ctrl, 25'h8);
    check("s0_replace_data",  ib.o_data, 90'h88);
    ib.i_valid = 1'b0;
    step();
    check("s0_drain_valid", ib.o_valid, 0);

    // Narrow counter saturation, then flush with payload clearing.
    ic.i_ready = 1'b0;
    ic.i_valid = 1'b1; ic.i_ctrl = 25'h3; ic.i_data = 90'h33;
    step();
    ic.i_valid = 1'b0;
    for (int k = 0; k < 20; k++) step();
    check("sat_cnt",  ic.o_stall_cnt, 15);
    check("sat_ctrl", ic.o_ctrl, 25'h3);
    ic.i_flush = 1'b1;
    step();
    check("clr_flush_valid", ic.o_valid, 0);
    check("clr_flush_data",  ic.o_data, 0);
    check("clr_flush_cnt",   ic.o_stall_cnt, 15);

    // Reset beats flush and a concurrent accept.
    ic.i_flush = 1'b0;
    ic.i_valid = 1'b1; ic.i_ctrl = 25'h9; ic.i_data = 90'h99;
    step();
    check("prio_loaded_ctrl", ic.o_ctrl, 25'h9);
    rst = 1'b0;
    ic.i_flush = 1'b1; ic.i_ctrl = 25'h1F; ic.i_data = 90'h1F1F;
    step();
    check("prio_valid", ic.o_valid, 0);
    check("prio_ctrl",  ic.o_ctrl, 0);
    check("prio_data",  ic.o_data, 0);
    check("prio_ready", ic.o_ready, 1);
    check("prio_cnt",   ic.o_stall_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
